vm_multi_product: RTL and testbench

Parametrised multi-product vending controller. It accumulates 5 rs and 10 rs coins into a credit register and vends one of NUM_PROD products at per-product prices. Change and cancelled credit are returned as a serial stream of 5 rs pulses. It sits between the coin acceptor and selection panel on the input side and the dispenser and change hopper on the output side.

---
 rtl/vm_multi_product.sv | 128 ++++++++++++
 tb/tb_vm_multi_product.sv | 98 +++++++++
 2 files changed

// File: rtl/vm_multi_product.sv
// vm_multi_product: multi-product vending controller with serial 5 rs change return
//
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   coin         00 none, 01 = 5 rs, 10 = 10 rs, 11 = invalid
//   sel_valid    one-cycle product request, product id on sel_id
//   cancel       one-cycle refund request
//   out, out_id  one-cycle vend pulse and vended product (out_id holds last value)
//   change_5     one pulse per 5 rs returned
//   credit       current credit in 5 rs units
//   busy         high while vending or returning change
//   coin_reject  previous cycle's coin was not credited
//   sel_err      previous cycle's selection was refused
module vm_multi_product #(
   parameter int                     NUM_PROD   = 2,
   parameter int                     SEL_W      = 1,
   parameter int                     CW         = 6,
   parameter logic [NUM_PROD*CW-1:0] PRICES     = {6'd3, 6'd2},
   parameter int                     MAX_CREDIT = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       coin,
   input  logic             sel_valid,
   input  logic [SEL_W-1:0] sel_id,
   input  logic             cancel,
   output logic             out,
   output logic [SEL_W-1:0] out_id,
   output logic             change_5,
   output logic [CW-1:0]    credit,
   output logic             busy,
   output logic             coin_reject,
   output logic             sel_err
);
   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    credit_q, credit_d, price;
   logic [SEL_W-1:0] out_id_q, out_id_d;
   logic             out_q, out_d, change_5_q, change_5_d, busy_q, busy_d;
   logic             coin_reject_q, coin_reject_d, sel_err_q, sel_err_d;
   logic             id_ok, coin_ok;
   logic [CW:0]      sum;
   always_comb begin
      price = '0;
      id_ok = 1'b0;
      for (int i = 0; i < NUM_PROD; i++)
         if (int'(sel_id) == i) begin
            price = PRICES[i*CW +: CW];
            id_ok = 1'b1;
         end
   end
   // Credit limit is checked one bit wider than the register so it never wraps.
   assign sum     = {1'b0, credit_q} + (coin == 2'b10 ? (CW+1)'(2) : (CW+1)'(1));
   assign coin_ok = (coin == 2'b01 || coin == 2'b10) && sum <= (CW+1)'(MAX_CREDIT);
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      out_d         = 1'b0;
      out_id_d      = out_id_q;
      change_5_d    = 1'b0;
      busy_d        = 1'b0;
      coin_reject_d = coin != 2'b00;
      sel_err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cancel) begin
               // First change pulse is issued together with the move to CHANGE.
               if (credit_q != '0) begin
                  state_d    = CHANGE;
                  credit_d   = credit_q - 1'b1;
                  change_5_d = 1'b1;
                  busy_d     = 1'b1;
               end
            end else if (sel_valid) begin
               if (id_ok && credit_q >= price) begin
                  state_d  = VEND;
                  credit_d = credit_q - price;
                  out_d    = 1'b1;
                  out_id_d = sel_id;
                  busy_d   = 1'b1;
               end else
                  sel_err_d = 1'b1;
            end else if (coin_ok) begin
               credit_d      = sum[CW-1:0];
               coin_reject_d = 1'b0;
            end
         end
         default: begin
            // VEND and CHANGE both drain remaining credit one unit per cycle.
            if (credit_q != '0) begin
               state_d    = CHANGE;
               credit_d   = credit_q - 1'b1;
               change_5_d = 1'b1;
               busy_d     = 1'b1;
            end else
               state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         out_q         <= 1'b0;
         out_id_q      <= '0;
         change_5_q    <= 1'b0;
         busy_q        <= 1'b0;
         coin_reject_q <= 1'b0;
         sel_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         out_q         <= out_d;
         out_id_q      <= out_id_d;
         change_5_q    <= change_5_d;
         busy_q        <= busy_d;
         coin_reject_q <= coin_reject_d;
         sel_err_q     <= sel_err_d;
      end
   end
   assign out         = out_q;
   assign out_id      = out_id_q;
   assign change_5    = change_5_q;
   assign credit      = credit_q;
   assign busy        = busy_q;
   assign coin_reject = coin_reject_q;
   assign sel_err     = sel_err_q;
endmodule

// File: tb/tb_vm_multi_product.sv
// tb_vm_multi_product: directed self-checking bench for vm_multi_product
module tb_vm_multi_product;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] coin = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_id = 2'b00;
   logic       cancel = 1'b0;
   logic       out, change_5, busy, coin_reject, sel_err;
   logic [1:0] out_id;
   logic [5:0] credit;
   int         passed = 0;
   int         total = 0;

   vm_multi_product #(.NUM_PROD(2), .SEL_W(2), .CW(6), .PRICES({6'd3, 6'd2}), .MAX_CREDIT(20)) dut (
      .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
      .out(out), .out_id(out_id), .change_5(change_5), .credit(credit), .busy(busy),
      .coin_reject(coin_reject), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] sid, input logic cn);
      coin = c; sel_valid = sv; sel_id = sid; cancel = cn;
      @(posedge clk); #1;
      coin = 2'b00; sel_valid = 1'b0; sel_id = 2'b00; cancel = 1'b0;
   endtask

   task automatic idle();
      cyc(2'b00, 1'b0, 2'b00, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_credit", credit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out", out, 0);
      chk("rst_change", change_5, 0);
      chk("rst_reject", coin_reject, 0);
      chk("rst_selerr", sel_err, 0);
      chk("rst_outid", out_id, 0);
      rst = 1'b0;
      // exact-price vend, no change
      cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t1_credit1", credit, 1);
      cyc(2'b10, 1'b0, 2'b00, 1'b0); chk("t1_credit3", credit, 3);
      cyc(2'b00, 1'b1, 2'd1, 1'b0);
      chk("t1_out", out, 1); chk("t1_outid", out_id, 1); chk("t1_credit0", credit, 0); chk("t1_busy", busy, 1);
      idle();
      chk("t1_out_low", out, 0); chk("t1_busy_low", busy, 0); chk("t1_nochange", change_5, 0);
      // vend with two units of change
      cyc(2'b10, 1'b0, 2'b00, 1'b0); cyc(2'b10, 1'b0, 2'b00, 1'b0); chk("t2_credit4", credit, 4);
      cyc(2'b00, 1'b1, 2'd0, 1'b0);
      chk("t2_out", out, 1); chk("t2_outid", out_id, 0); chk("t2_credit2", credit, 2); chk("t2_vend_nochg", change_5, 0);
      idle(); chk("t2_chg1", change_5, 1); chk("t2_credit1", credit, 1); chk("t2_busy1", busy, 1); chk("t2_out_low", out, 0);
      idle(); chk("t2_chg2", change_5, 1); chk("t2_credit_0", credit, 0); chk("t2_busy2", busy, 1);
      idle(); chk("t2_chg_done", change_5, 0); chk("t2_busy_done", busy, 0); chk("t2_outid_hold", out_id, 0);
      // credit ceiling
      for (int i = 0; i < 9; i++) cyc(2'b10, 1'b0, 2'b00, 1'b0);
      cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t3_credit19", credit, 19);
      cyc(2'b10, 1'b0, 2'b00, 1'b0); chk("t3_rej_over", coin_reject, 1); chk("t3_credit19_hold", credit, 19);
      cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t3_credit20", credit, 20); chk("t3_accept", coin_reject, 0);
      cyc(2'b11, 1'b0, 2'b00, 1'b0); chk("t3_rej_invalid", coin_reject, 1); chk("t3_credit20_hold", credit, 20);
      cyc(2'b00, 1'b0, 2'b00, 1'b1); chk("t3_cancel_chg", change_5, 1); chk("t3_cancel_credit", credit, 19);
      for (int i = 0; i < 19; i++) idle();
      chk("t3_last_chg", change_5, 1); chk("t3_last_credit", credit, 0); chk("t3_last_busy", busy, 1);
      idle(); chk("t3_drained_busy", busy, 0); chk("t3_drained_chg", change_5, 0);
      // cancel with a coin in the same cycle
      cyc(2'b10, 1'b0, 2'b00, 1'b0); cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t4_credit3", credit, 3);
      cyc(2'b10, 1'b0, 2'b00, 1'b1);
      chk("t4_reject", coin_reject, 1); chk("t4_chg1", change_5, 1); chk("t4_credit2", credit, 2); chk("t4_busy", busy, 1);
      idle(); chk("t4_chg2", change_5, 1); chk("t4_credit1", credit, 1); chk("t4_noout2", out, 0);
      idle(); chk("t4_chg3", change_5, 1); chk("t4_credit0", credit, 0); chk("t4_noout3", out, 0);
      idle(); chk("t4_chg_end", change_5, 0); chk("t4_busy_end", busy, 0);
      cyc(2'b00, 1'b0, 2'b00, 1'b1); chk("t4_zero_cancel_chg", change_5, 0); chk("t4_zero_cancel_busy", busy, 0);
      // refused selections
      cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t5_credit1", credit, 1);
      cyc(2'b00, 1'b1, 2'd1, 1'b0); chk("t5_selerr_price", sel_err, 1); chk("t5_credit_kept", credit, 1); chk("t5_noout", out, 0);
      idle(); chk("t5_selerr_low", sel_err, 0);
      cyc(2'b00, 1'b1, 2'd3, 1'b0); chk("t5_selerr_id", sel_err, 1); chk("t5_id_noout", out, 0);
      // reset during change return
      cyc(2'b10, 1'b0, 2'b00, 1'b0); cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t6_credit4", credit, 4);
      cyc(2'b00, 1'b1, 2'd0, 1'b0); chk("t6_out", out, 1); chk("t6_credit2", credit, 2);
      idle(); chk("t6_chg1", change_5, 1); chk("t6_credit1", credit, 1);
      rst = 1'b1; idle(); rst = 1'b0;
      chk("t6_rst_credit", credit, 0); chk("t6_rst_chg", change_5, 0); chk("t6_rst_busy", busy, 0);
      idle(); chk("t6_post_chg", change_5, 0); chk("t6_post_busy", busy, 0);
      cyc(2'b01, 1'b0, 2'b00, 1'b0); chk("t6_coin_ok", credit, 1); chk("t6_coin_noreject", coin_reject, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
